// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the regfile write-port arbiter: pipeline writeback, long-latency results,
// issue/decode scoreboard queries and the regfile write port.
interface regfile_wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;

    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;

    logic        issue_en;
    logic [4:0]  issue_addr;

    logic [4:0]  chk_rs_addr;
    logic [4:0]  chk_rt_addr;
    logic [4:0]  chk_rd_addr;
    logic        stall;
    logic        pipe_hold;

    logic        regfile_write_enable;
    logic [4:0]  regfile_write_addr;
    logic [31:0] regfile_write_data;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        output lu_ready,
        input  issue_en, issue_addr,
        input  chk_rs_addr, chk_rt_addr, chk_rd_addr,
        output stall, pipe_hold,
        output regfile_write_enable, regfile_write_addr, regfile_write_data
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        input  lu_ready,
        output issue_en, issue_addr,
        output chk_rs_addr, chk_rt_addr, chk_rd_addr,
        input  stall, pipe_hold,
        input  regfile_write_enable, regfile_write_addr, regfile_write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority, long-latency results queue in a FIFO,
// busy scoreboard drives decode stall. Define WB_STARVE_GUARD_EN to add the starvation guard (pipe_hold).
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("regfile_wb_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [4:0]  addr_mem [FIFO_DEPTH];
    logic [31:0] data_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        pipe_own;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic [31:0] busy;
    logic [31:0] busy_next;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_addr = addr_mem[rd_ptr[AW-1:0]];
    assign head_data = data_mem[rd_ptr[AW-1:0]];

    assign pipe_own     = bus.pipe_we && (bus.pipe_waddr != 5'd0);
    assign pop          = !pipe_own && !empty;
    assign bus.lu_ready = !full && !rst;
    assign push         = bus.lu_valid && bus.lu_ready;

    always_comb begin
        bus.regfile_write_enable = 1'b0;
        bus.regfile_write_addr   = 5'd0;
        bus.regfile_write_data   = 32'd0;
        if (pipe_own) begin
            bus.regfile_write_enable = 1'b1;
            bus.regfile_write_addr   = bus.pipe_waddr;
            bus.regfile_write_data   = bus.pipe_wdata;
        end else if (!empty) begin
            bus.regfile_write_enable = 1'b1;
            bus.regfile_write_addr   = head_addr;
            bus.regfile_write_data   = head_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr[AW-1:0]] <= bus.lu_waddr;
            data_mem[wr_ptr[AW-1:0]] <= bus.lu_wdata;
        end
    end

    // Clear is applied before set so a same-cycle issue to the popped register stays busy.
    always_comb begin
        busy_next = busy;
        if (pop && head_addr != 5'd0) busy_next[head_addr] = 1'b0;
        if (bus.issue_en && bus.issue_addr != 5'd0) busy_next[bus.issue_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    // Sources being written by the head this cycle are forwarded by the regfile; rd still waits (WAW).
    always_comb begin
        bus.stall = 1'b0;
        if (bus.chk_rs_addr != 5'd0 && busy[bus.chk_rs_addr] && !(pop && head_addr == bus.chk_rs_addr))
            bus.stall = 1'b1;
        if (bus.chk_rt_addr != 5'd0 && busy[bus.chk_rt_addr] && !(pop && head_addr == bus.chk_rt_addr))
            bus.stall = 1'b1;
        if (bus.chk_rd_addr != 5'd0 && busy[bus.chk_rd_addr])
            bus.stall = 1'b1;
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] BLK_MAX = CW'(STARVE_LIMIT - 1);

    logic          blocked;
    logic [CW-1:0] blk_cnt;
    logic          hold_q;

    assign blocked = !empty && pipe_own;

    // Counter saturates so a pipeline ignoring pipe_hold gets re-held every other cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
            hold_q  <= 1'b0;
        end else begin
            if (pop)
                blk_cnt <= '0;
            else if (blocked && blk_cnt != BLK_MAX)
                blk_cnt <= blk_cnt + CW'(1);
            hold_q <= blocked && (blk_cnt == BLK_MAX) && !hold_q;
        end
    end

    assign bus.pipe_hold = hold_q;
`else
    assign bus.pipe_hold = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: LU results go into a scoreboard queue on acceptance
// and are popped and compared whenever the DUT writes the regfile from its FIFO.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst;
    int   passCount  = 0;
    int   checkCount = 0;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic [36:0] luQ [$];

    regfile_wb_arbiter_if bus_if ();

    regfile_wb_arbiter #(
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic applyStimulus(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic ie, input logic [4:0] ia);
        @(posedge clk);
        #1;
        bus_if.pipe_we    = pwe;
        bus_if.pipe_waddr = pa;
        bus_if.pipe_wdata = pd;
        bus_if.lu_valid   = lv;
        bus_if.lu_waddr   = la;
        bus_if.lu_wdata   = ld;
        bus_if.issue_en   = ie;
        bus_if.issue_addr = ia;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Write-port monitor and scoreboard, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.pipe_we && bus_if.pipe_waddr != 5'd0) begin
                checkOutput("pipe_wb_en",   bus_if.regfile_write_enable, 1'b1);
                checkOutput("pipe_wb_addr", bus_if.regfile_write_addr, bus_if.pipe_waddr);
                checkOutput("pipe_wb_data", bus_if.regfile_write_data, bus_if.pipe_wdata);
            end else if (luQ.size() > 0) begin
                logic [36:0] e;
                e = luQ.pop_front();
                checkOutput("lu_wb_en",   bus_if.regfile_write_enable, 1'b1);
                checkOutput("lu_wb_addr", bus_if.regfile_write_addr, e[36:32]);
                checkOutput("lu_wb_data", bus_if.regfile_write_data, e[31:0]);
            end else begin
                checkOutput("idle_wb_en", bus_if.regfile_write_enable, 1'b0);
            end
            if (bus_if.lu_valid && bus_if.lu_ready)
                luQ.push_back({bus_if.lu_waddr, bus_if.lu_wdata});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus_if.pipe_we = 1'b0;  bus_if.pipe_waddr = 5'd0;  bus_if.pipe_wdata = 32'd0;
        bus_if.lu_valid = 1'b0; bus_if.lu_waddr = 5'd0;    bus_if.lu_wdata = 32'd0;
        bus_if.issue_en = 1'b0; bus_if.issue_addr = 5'd0;
        bus_if.chk_rs_addr = 5'd0; bus_if.chk_rt_addr = 5'd0; bus_if.chk_rd_addr = 5'd0;

        // Reset state
        #2;
        checkOutput("rst_we",       bus_if.regfile_write_enable, 1'b0);
        checkOutput("rst_lu_ready", bus_if.lu_ready, 1'b0);
        checkOutput("rst_stall",    bus_if.stall, 1'b0);
        checkOutput("rst_hold",     bus_if.pipe_hold, 1'b0);
        bus_if.pipe_we = 1'b1; bus_if.pipe_waddr = 5'd3; bus_if.pipe_wdata = 32'h11;
        #1;
        checkOutput("rst_pipe_we",   bus_if.regfile_write_enable, 1'b1);
        checkOutput("rst_pipe_addr", bus_if.regfile_write_addr, 5'd3);
        bus_if.pipe_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Pipeline pass-through
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        checkOutput("pass_we",    bus_if.regfile_write_enable, 1'b1);
        checkOutput("pass_addr",  bus_if.regfile_write_addr, 5'd3);
        checkOutput("pass_data",  bus_if.regfile_write_data, 32'h11);
        checkOutput("pass_ready", bus_if.lu_ready, 1'b1);

        // Issue to r8, stall, then result with forwarding
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
        #1;
        checkOutput("issue_nostall", bus_if.stall, 1'b0);
        idle();
        bus_if.chk_rs_addr = 5'd8;
        #1;
        checkOutput("busy8_stall", bus_if.stall, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD, 1'b0, 5'd0);
        #1;
        checkOutput("busy8_stall_acc", bus_if.stall, 1'b1);
        idle();
        #1;
        checkOutput("fwd_rs8_stall", bus_if.stall, 1'b0);
        checkOutput("fwd_addr",      bus_if.regfile_write_addr, 5'd8);
        bus_if.chk_rd_addr = 5'd8;
        #1;
        checkOutput("waw_rd8_stall", bus_if.stall, 1'b1);
        bus_if.chk_rd_addr = 5'd0;
        idle();
        #1;
        checkOutput("busy8_cleared", bus_if.stall, 1'b0);
        bus_if.chk_rs_addr = 5'd0;

        // Starvation: pipeline writes every cycle while (5, 0x55) waits
        applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 5'd1, 32'h100 + k, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            if (bus_if.pipe_hold) bus_if.pipe_we = 1'b0;
            #1;
            checkOutput($sformatf("starve_hold_%0d", k), bus_if.pipe_hold, (GUARD && k == 5));
            checkOutput($sformatf("starve_ready_%0d", k), bus_if.lu_ready, 1'b1);
        end
        idle();
        idle();

        // FIFO full back-pressure and ordering
        applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd2, 32'h201, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd2, 32'h202, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0);
        #1;
        checkOutput("full_ready_c", bus_if.lu_ready, 1'b0);
        applyStimulus(1'b1, 5'd2, 32'h203, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0);
        #1;
        checkOutput("full_ready_d", bus_if.lu_ready, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0);
        #1;
        checkOutput("full_ready_pop", bus_if.lu_ready, 1'b0);
        checkOutput("full_pop_addr",  bus_if.regfile_write_addr, 5'd6);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0);
        #1;
        checkOutput("after_pop_ready", bus_if.lu_ready, 1'b1);
        idle();
        idle();
        #1;
        checkOutput("drained_we", bus_if.regfile_write_enable, 1'b0);

        // Same-edge set and clear of r9: set wins
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        bus_if.chk_rs_addr = 5'd9;
        #1;
        checkOutput("r9_fwd_stall", bus_if.stall, 1'b0);
        idle();
        #1;
        checkOutput("r9_set_wins", bus_if.stall, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h98, 1'b0, 5'd0);
        idle();
        idle();
        #1;
        checkOutput("r9_cleared", bus_if.stall, 1'b0);

        // r0 entry pops without touching busy[4]
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        bus_if.chk_rs_addr = 5'd4;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
        idle();
        #1;
        checkOutput("r0_pop_addr", bus_if.regfile_write_addr, 5'd0);
        checkOutput("r0_pop_data", bus_if.regfile_write_data, 32'h1234);
        idle();
        #1;
        checkOutput("busy4_kept", bus_if.stall, 1'b1);

        // Async reset with two entries queued and busy[4] set
        applyStimulus(1'b1, 5'd1, 32'h300, 1'b1, 5'd11, 32'hB1, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd1, 32'h301, 1'b1, 5'd12, 32'hB2, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd1, 32'h302, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        checkOutput("pre_rst_ready", bus_if.lu_ready, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_stall", bus_if.stall, 1'b0);
        checkOutput("arst_hold",  bus_if.pipe_hold, 1'b0);
        checkOutput("arst_ready", bus_if.lu_ready, 1'b0);
        checkOutput("arst_pipe_addr", bus_if.regfile_write_addr, 5'd1);
        bus_if.pipe_we = 1'b0;
        #1;
        checkOutput("arst_empty_we", bus_if.regfile_write_enable, 1'b0);
        luQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        #1;
        checkOutput("post_rst_ready", bus_if.lu_ready, 1'b1);
        checkOutput("post_rst_stall", bus_if.stall, 1'b0);
        checkOutput("post_rst_we",    bus_if.regfile_write_enable, 1'b0);
        bus_if.chk_rs_addr = 5'd0;
        idle();
        idle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
